// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//
// Inverse of the core's immediate decoder. A 32-bit immediate is scattered
// into the bit positions of the selected instruction format, on top of a
// base instruction word that supplies opcode/rd/rs/funct bits. Results pass
// through a two-stage valid/ready pipeline (stage A = encode, stage B =
// output) and errored beats are counted by a saturating counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_extop[2:0]         format: 000 I, 001 U, 010 S, 011 B, 100 J,
//                         101 I-shift, 111 none, 110 illegal
//   in_imm[31:0]          immediate in the decoder's output domain
//   in_base[31:0]         instruction template
//   out_valid/out_ready   output handshake
//   out_instr[31:0]       encoded instruction
//   out_err               beat had a range error or illegal extop
//   err_cnt               saturating count of errored beats leaving stage B
//
// Parameters:
//   ERR_CNT_W             width of err_cnt
//   PASS_BASE_ON_ERR      1: errored beats emit in_base unmodified,
//                         0: errored beats emit the truncated encoding
//
// Build option:
//   IMM_ENC_RANGE_CHECK_EN  when defined, immediates that the format cannot
//                           represent raise out_err. When undefined only
//                           extop 110 raises out_err and out-of-range
//                           immediates are silently truncated.
// ---------------------------------------------------------------------------
module imm_encoder #(
   parameter int ERR_CNT_W        = 8,
   parameter bit PASS_BASE_ON_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_extop,
   input  logic [31:0]          in_imm,
   input  logic [31:0]          in_base,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic                 a_valid_q, a_valid_d;
   logic [31:0]          a_instr_q, a_instr_d;
   logic                 a_err_q,   a_err_d;
   logic                 b_valid_q, b_valid_d;
   logic [31:0]          b_instr_q, b_instr_d;
   logic                 b_err_q,   b_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic        a_ready;
   logic        in_fire;
   logic        out_fire;
   logic [31:0] enc_instr;
   logic        enc_err;
   logic        range_bad;

`ifdef IMM_ENC_RANGE_CHECK_EN
   // An immediate is representable when every bit above the format's top
   // field bit is a copy of that sign bit; B/J formats additionally have an
   // implicit zero LSB, and I-shift has no encoding for imm[10].
   logic i_ok;
   logic b_ok;
   logic j_ok;

   always_comb begin
      i_ok      = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      b_ok      = (&in_imm[31:12]) | ~(|in_imm[31:12]);
      j_ok      = (&in_imm[31:20]) | ~(|in_imm[31:20]);
      range_bad = 1'b0;
      case (in_extop)
         3'b000:  range_bad = ~i_ok;
         3'b001:  range_bad = |in_imm[11:0];
         3'b010:  range_bad = ~i_ok;
         3'b011:  range_bad = ~b_ok | in_imm[0];
         3'b100:  range_bad = ~j_ok | in_imm[0];
         3'b101:  range_bad = ~i_ok | in_imm[10];
         default: range_bad = 1'b0;
      endcase
   end
`else
   assign range_bad = 1'b0;
`endif

   // Scatter the immediate into the format's fields over the base word.
   // I-shift keeps base bit 30 so the funct7 distinction (SRLI/SRAI)
   // survives, which is why imm[10] has no home in that format.
   always_comb begin
      enc_instr = in_base;
      enc_err   = range_bad;
      case (in_extop)
         3'b000: enc_instr[31:20] = in_imm[11:0];
         3'b001: enc_instr[31:12] = in_imm[31:12];
         3'b010: begin
            enc_instr[31:25] = in_imm[11:5];
            enc_instr[11:7]  = in_imm[4:0];
         end
         3'b011: begin
            enc_instr[31]    = in_imm[12];
            enc_instr[7]     = in_imm[11];
            enc_instr[30:25] = in_imm[10:5];
            enc_instr[11:8]  = in_imm[4:1];
         end
         3'b100: begin
            enc_instr[31]    = in_imm[20];
            enc_instr[19:12] = in_imm[19:12];
            enc_instr[20]    = in_imm[11];
            enc_instr[30:21] = in_imm[10:1];
         end
         3'b101: begin
            enc_instr[31]    = in_imm[11];
            enc_instr[29:20] = in_imm[9:0];
         end
         3'b110:  enc_err = 1'b1;
         default: enc_err = 1'b0;
      endcase
      if (enc_err && PASS_BASE_ON_ERR) begin
         enc_instr = in_base;
      end
   end

   // Handshake and next-state for both pipeline stages and the error
   // counter. Stage A drains into B whenever B is empty or being emptied,
   // so a full pipeline still sustains one beat per cycle.
   always_comb begin
      a_ready   = ~b_valid_q | out_ready;
      in_ready  = ~a_valid_q | a_ready;
      in_fire   = in_valid & in_ready;
      out_fire  = b_valid_q & out_ready;

      a_valid_d = a_valid_q;
      a_instr_d = a_instr_q;
      a_err_d   = a_err_q;
      b_valid_d = b_valid_q;
      b_instr_d = b_instr_q;
      b_err_d   = b_err_q;
      err_cnt_d = err_cnt_q;

      if (in_fire) begin
         a_valid_d = 1'b1;
         a_instr_d = enc_instr;
         a_err_d   = enc_err;
      end else if (a_ready) begin
         a_valid_d = 1'b0;
      end

      if (a_ready) begin
         b_valid_d = a_valid_q;
         if (a_valid_q) begin
            b_instr_d = a_instr_q;
            b_err_d   = a_err_q;
         end
      end

      if (out_fire && b_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   // State registers; reset discards any in-flight beats immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q <= 1'b0;
         a_instr_q <= '0;
         a_err_q   <= 1'b0;
         b_valid_q <= 1'b0;
         b_instr_q <= '0;
         b_err_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         a_instr_q <= a_instr_d;
         a_err_q   <= a_err_d;
         b_valid_q <= b_valid_d;
         b_instr_q <= b_instr_d;
         b_err_q   <= b_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_valid = b_valid_q;
   assign out_instr = b_instr_q;
   assign out_err   = b_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
//
// Directed bench for imm_encoder: reset values, per-format encodings with
// hand-computed words, two-cycle latency, backpressure with hold/ordering,
// counter saturation, mid-stream reset and a decode round trip for random
// in-range immediates. Expected error flags follow IMM_ENC_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_extop;
   logic [31:0] in_imm;
   logic [31:0] in_base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [7:0]  err_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

`ifdef IMM_ENC_RANGE_CHECK_EN
   localparam logic RANGE_ERR = 1'b1;
`else
   localparam logic RANGE_ERR = 1'b0;
`endif

   imm_encoder #(
      .ERR_CNT_W        (8),
      .PASS_BASE_ON_ERR (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_extop  (in_extop),
      .in_imm    (in_imm),
      .in_base   (in_base),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Saturating update of the model error counter.
   task automatic bumpCount(input logic err);
      if (err && exp_cnt < 255) exp_cnt++;
   endtask

   // One isolated beat with out_ready high: checks acceptance and the
   // two-edge latency, then returns what appeared on the output. The beat
   // is consumed on the edge after it is sampled.
   task automatic applyStimulus(input string tag, input logic [2:0] extop,
                                input logic [31:0] imm, input logic [31:0] base,
                                output logic [31:0] got_instr, output logic got_err);
      @(negedge clk);
      in_valid  = 1'b1;
      in_extop  = extop;
      in_imm    = imm;
      in_base   = base;
      out_ready = 1'b1;
      #1;
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
      got_instr = out_instr;
      got_err   = out_err;
   endtask

   // Directed beat with a hand-computed expected word and error flag.
   task automatic directedBeat(input string tag, input logic [2:0] extop,
                               input logic [31:0] imm, input logic [31:0] base,
                               input logic [31:0] exp_instr, input logic exp_err);
      logic [31:0] gi;
      logic        ge;
      applyStimulus(tag, extop, imm, base, gi, ge);
      checkOutput({tag, "_instr"}, gi, exp_instr);
      checkOutput({tag, "_err"}, 32'(ge), 32'(exp_err));
      bumpCount(exp_err);
   endtask

   // Reference decoder, written from the format tables independently of
   // the encoder's scatter logic.
   function automatic logic [31:0] decodeImm(input logic [2:0] f, input logic [31:0] i);
      case (f)
         3'b000:  return {{20{i[31]}}, i[31:20]};
         3'b001:  return {i[31:12], 12'b0};
         3'b010:  return {{20{i[31]}}, i[31:25], i[11:7]};
         3'b011:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'b101:  return {{21{i[31]}}, 1'b0, i[29:20]};
         default: return i;
      endcase
   endfunction

   // Bits owned by the immediate in each format; all others come from base.
   function automatic logic [31:0] immMask(input logic [2:0] f);
      case (f)
         3'b000:  return 32'hFFF0_0000;
         3'b001:  return 32'hFFFF_F000;
         3'b010:  return 32'hFE00_0F80;
         3'b011:  return 32'hFE00_0F80;
         3'b100:  return 32'hFFFF_F000;
         3'b101:  return 32'hBFF0_0000;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Random immediate that the format can represent exactly.
   function automatic logic [31:0] inRangeImm(input logic [2:0] f, input logic [31:0] r);
      case (f)
         3'b001:  return {r[31:12], 12'b0};
         3'b011:  return {{19{r[12]}}, r[12:1], 1'b0};
         3'b100:  return {{11{r[20]}}, r[20:1], 1'b0};
         3'b101:  return {{21{r[11]}}, 1'b0, r[9:0]};
         default: return {{20{r[11]}}, r[11:0]};
      endcase
   endfunction

   // Main sequence.
   initial begin
      logic [2:0]  bp_ext   [4] = '{3'b001, 3'b010, 3'b111, 3'b110};
      logic [31:0] bp_imm   [4] = '{32'h1234_5000, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h0};
      logic [31:0] bp_base  [4] = '{32'h0000_0037, 32'h0000_2023, 32'h0010_0073, 32'h0000_000B};
      logic [31:0] bp_instr [4] = '{32'h1234_5037, 32'hFE00_2E23, 32'h0010_0073, 32'h0000_000B};
      logic        bp_err   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [32:0] exp_q [$];
      int          sent;
      int          rcvd;
      logic        saw_stall;
      logic        hold_pending;
      logic [31:0] held_instr;
      logic [31:0] r;
      logic [31:0] imm;
      logic [31:0] base;
      logic [31:0] gi;
      logic        ge;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_extop  = 3'b000;
      in_imm    = '0;
      in_base   = '0;
      out_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_instr", out_instr, 32'd0);
      checkOutput("rst_out_err", 32'(out_err), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed encodings.
      directedBeat("i_ones",  3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
      directedBeat("b_neg",   3'b011, 32'hFFFF_F800, 32'h0000_0063, 32'h8000_00E3, 1'b0);
      directedBeat("j_800",   3'b100, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
      directedBeat("ishift",  3'b101, 32'h0000_0005, 32'h4000_5013, 32'h4050_5013, 1'b0);
      directedBeat("i_range", 3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, RANGE_ERR);
      directedBeat("illegal", 3'b110, 32'h1234_5678, 32'h0000_0033, 32'h0000_0033, 1'b1);
      @(negedge clk);
      checkOutput("directed_err_cnt", 32'(err_cnt), 32'(exp_cnt));

      // Back-to-back beats with out_ready low for three cycles mid-stream.
      sent         = 0;
      rcvd         = 0;
      saw_stall    = 1'b0;
      hold_pending = 1'b0;
      held_instr   = '0;
      for (int c = 0; c < 40 && rcvd < 4; c++) begin
         @(negedge clk);
         if (hold_pending) begin
            checkOutput("bp_hold", out_instr, held_instr);
            hold_pending = 1'b0;
         end
         out_ready = !(c >= 2 && c <= 4);
         if (sent < 4) begin
            in_valid = 1'b1;
            in_extop = bp_ext[sent];
            in_imm   = bp_imm[sent];
            in_base  = bp_base[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!in_ready) saw_stall = 1'b1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("bp_spurious", 32'd1, 32'd0);
            end else begin
               checkOutput("bp_instr", out_instr, exp_q[0][31:0]);
               checkOutput("bp_err", 32'(out_err), 32'(exp_q[0][32]));
               bumpCount(exp_q[0][32]);
               void'(exp_q.pop_front());
            end
            rcvd++;
         end else if (out_valid) begin
            hold_pending = 1'b1;
            held_instr   = out_instr;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({bp_err[sent], bp_instr[sent]});
            sent++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_received", 32'(rcvd), 32'd4);
      checkOutput("bp_stall_seen", 32'(saw_stall), 32'd1);
      @(negedge clk);
      checkOutput("bp_err_cnt", 32'(err_cnt), 32'(exp_cnt));

      // Round trip: random in-range immediates for every encodable format.
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 3; k++) begin
            r    = $urandom;
            imm  = inRangeImm(3'(f), r);
            base = $urandom;
            applyStimulus("rt", 3'(f), imm, base, gi, ge);
            checkOutput("rt_decode", decodeImm(3'(f), gi), imm);
            checkOutput("rt_base_bits", gi & ~immMask(3'(f)), base & ~immMask(3'(f)));
            checkOutput("rt_err", 32'(ge), 32'd0);
         end
      end

      // 300 illegal beats streamed back to back: counter must saturate.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_extop  = 3'b110;
      in_imm    = '0;
      in_base   = 32'h0000_0013;
      repeat (300) @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int n = 0; n < 300; n++) bumpCount(1'b1);
      checkOutput("sat_err_cnt", 32'(err_cnt), 32'(exp_cnt));

      // Reset with two beats in flight and the output stalled.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_extop  = 3'b110;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      checkOutput("midrst_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("midrst_instr", out_instr, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midrst_no_resurrect", 32'(out_valid), 32'd0);
      checkOutput("midrst_cnt_after", 32'(err_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
